// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory request/acknowledge
// transaction with alignment check, bounded wait and the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_data_i,
    input  logic [4:0]  rd_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  rd_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  wb_q, wb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  rd_q, rd_d;
    logic        mis_q, mis_d;
    logic        to_q, to_d;
    logic        stall;
    logic        access;
    logic        aligned;
    logic        is_load;

    assign access  = MemRead_i | MemWrite_i;
    assign aligned = (Address_i[1:0] == 2'b00);
    // Read and write together behave as a store.
    assign is_load = MemRead_i & ~MemWrite_i;

    // Handshake: dmem_req_o is high for every WAIT cycle and the request
    // fields are held by the frozen EX/MEM register; the transaction ends in
    // the one cycle dmem_ack_i is seen while dmem_req_o is high.
    assign dmem_req_o   = (state_q == S_WAIT) & ~rst;
    assign dmem_we_o    = MemWrite_i;
    assign dmem_addr_o  = Address_i;
    assign dmem_wdata_o = Write_data_i;
    assign stall_o      = stall & ~rst;

    assign WB_o        = wb_q;
    assign ReadData_o  = rdata_q;
    assign ALUResult_o = alu_q;
    assign rd_o        = rd_q;
    assign misalign_o  = mis_q;
    assign timeout_o   = to_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wb_d    = wb_q;
        rdata_d = rdata_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        mis_d   = 1'b0;
        to_d    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && aligned) begin
                    stall   = 1'b1;
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                    wb_d    = 2'b00;
                end else begin
                    // Misaligned accesses are dropped and leave a bubble.
                    wb_d    = access ? 2'b00 : WB_i;
                    alu_d   = Address_i;
                    rd_d    = rd_i;
                    rdata_d = 32'd0;
                    mis_d   = access;
                end
            end
            S_WAIT: begin
                if (dmem_ack_i) begin
                    state_d = S_IDLE;
                    wb_d    = WB_i;
                    alu_d   = Address_i;
                    rd_d    = rd_i;
                    rdata_d = is_load ? dmem_rdata_i : 32'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    wb_d    = 2'b00;
                    alu_d   = Address_i;
                    rd_d    = rd_i;
                    rdata_d = 32'd0;
                    to_d    = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    wb_d  = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            wb_q    <= 2'b00;
            rdata_q <= 32'd0;
            alu_q   <= 32'd0;
            rd_q    <= 5'd0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

endmodule
